// File: rtl/memory_loader_if.sv
// +--------------------------------------------------------------------------+
// | memory_loader_if : host word stream (valid/ready) into the memory loader |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface memory_loader_if #(
  parameter int WORD_SIZE = 16
);
  logic                 in_valid;
  logic [WORD_SIZE-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

`default_nettype wire

// File: rtl/memory_loader.sv
// +--------------------------------------------------------------------------+
// | memory_loader : writes N/tol/step to slots 5..7, then an N-word vector   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module memory_loader #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  memory_loader_if.slave           host,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error_size
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_N    = 3'd1;
  localparam logic [2:0] GET_TOL  = 3'd2;
  localparam logic [2:0] GET_STEP = 3'd3;
  localparam logic [2:0] GET_VEC  = 3'd4;
  localparam logic [2:0] ERROR    = 3'd5;

  // Wide enough for both the raw N and the value 2^ADDRESS_WIDTH
  localparam int CHECK_WIDTH = (WORD_SIZE > ADDRESS_WIDTH + 1) ? WORD_SIZE : ADDRESS_WIDTH + 1;
  localparam int COUNT_WIDTH = ADDRESS_WIDTH + 1;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_N    = ADDRESS_WIDTH'(5);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_TOL  = ADDRESS_WIDTH'(6);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(7);

  logic [2:0]               state;
  logic [COUNT_WIDTH-1:0]   count;
  logic [ADDRESS_WIDTH-1:0] pointer;
  logic                     accept;
  logic                     n_valid;
  logic [CHECK_WIDTH-1:0]   n_ext;
  logic [CHECK_WIDTH-1:0]   n_limit;

  assign host.in_ready = (state == GET_N) || (state == GET_TOL) ||
                         (state == GET_STEP) || (state == GET_VEC);
  assign accept = host.in_valid & host.in_ready;

  // pointer still holds the latched base while in GET_N
  assign n_ext   = CHECK_WIDTH'(host.in_data);
  assign n_limit = (CHECK_WIDTH'(1) << ADDRESS_WIDTH) - CHECK_WIDTH'(pointer);
  assign n_valid = (n_ext != '0) && (n_ext <= n_limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      pointer     <= '0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error_size  <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE, ERROR: begin
          if (load) begin
            pointer    <= base_address;
            error_size <= 1'b0;
            busy       <= 1'b1;
            state      <= GET_N;
          end
        end
        GET_N: begin
          if (accept) begin
            if (n_valid) begin
              mem_write   <= 1'b1;
              mem_address <= ADDR_N;
              mem_data    <= host.in_data;
              count       <= n_ext[COUNT_WIDTH-1:0];
              state       <= GET_TOL;
            end else begin
              error_size <= 1'b1;
              busy       <= 1'b0;
              state      <= ERROR;
            end
          end
        end
        GET_TOL: begin
          if (accept) begin
            mem_write   <= 1'b1;
            mem_address <= ADDR_TOL;
            mem_data    <= host.in_data;
            state       <= GET_STEP;
          end
        end
        GET_STEP: begin
          if (accept) begin
            mem_write   <= 1'b1;
            mem_address <= ADDR_STEP;
            mem_data    <= host.in_data;
            state       <= GET_VEC;
          end
        end
        GET_VEC: begin
          if (accept) begin
            mem_write   <= 1'b1;
            mem_address <= pointer;
            mem_data    <= host.in_data;
            pointer     <= pointer + ADDRESS_WIDTH'(1);
            count       <= count - COUNT_WIDTH'(1);
            if (count == COUNT_WIDTH'(1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
